// File: rtl/pipe_reg_mem_wb_elastic.sv
// MEM/WB stage register with a valid/ready handshake and a two-entry skid buffer.
// in_ready is derived only from registered state, so WB backpressure never reaches MEM combinationally.
module pipe_reg_mem_wb_elastic #(
    parameter int unsigned DATA_W  = 20,
    parameter int unsigned INSTR_W = 20,
    parameter int unsigned OPC_MSB = 19,
    parameter int unsigned OPC_LSB = 16,
    parameter logic [OPC_MSB-OPC_LSB:0] LOAD_OPCODE = 4'h2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic [INSTR_W-1:0] instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  alu_out,
    output logic [DATA_W-1:0]  mem_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [DATA_W-1:0]  wb_data,
    output logic [1:0]         occupancy
);

    // Loads write back memory data; every other op writes back the ALU result.
    function automatic logic is_load(input logic [INSTR_W-1:0] instr);
        return (instr[OPC_MSB:OPC_LSB] == LOAD_OPCODE);
    endfunction

    logic               head_valid_q, head_valid_d;
    logic [DATA_W-1:0]  head_alu_q, head_alu_d;
    logic [DATA_W-1:0]  head_mem_q, head_mem_d;
    logic [INSTR_W-1:0] head_instr_q, head_instr_d;
    logic               skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]  skid_alu_q, skid_alu_d;
    logic [DATA_W-1:0]  skid_mem_q, skid_mem_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [1:0]         occ_q, occ_d;
    logic               accept_s;
    logic               pop_s;

    assign in_ready  = ~skid_valid_q & reset;
    assign out_valid = head_valid_q;
    assign alu_out   = head_alu_q;
    assign mem_out   = head_mem_q;
    assign instr_out = head_instr_q;
    assign occupancy = occ_q;
    assign wb_data   = is_load(head_instr_q) ? head_mem_q : head_alu_q;

    // Next-state selection for the head and skid entries; flush wins over accept and pop.
    always_comb begin
        accept_s     = in_valid & in_ready;
        pop_s        = head_valid_q & out_ready;
        head_valid_d = head_valid_q;
        head_alu_d   = head_alu_q;
        head_mem_d   = head_mem_q;
        head_instr_d = head_instr_q;
        skid_valid_d = skid_valid_q;
        skid_alu_d   = skid_alu_q;
        skid_mem_d   = skid_mem_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop_s && skid_valid_q) begin
            // Skid full means in_ready is low, so no accept can coincide with this move.
            head_valid_d = 1'b1;
            head_alu_d   = skid_alu_q;
            head_mem_d   = skid_mem_q;
            head_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
        end else if (accept_s && (!head_valid_q || pop_s)) begin
            head_valid_d = 1'b1;
            head_alu_d   = alu_result;
            head_mem_d   = mem_rdata;
            head_instr_d = instruction;
        end else if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_alu_d   = alu_result;
            skid_mem_d   = mem_rdata;
            skid_instr_d = instruction;
        end else if (pop_s) begin
            head_valid_d = 1'b0;
        end else begin
            head_valid_d = head_valid_q;
        end
        occ_d = {1'b0, head_valid_d} + {1'b0, skid_valid_d};
    end

    // Entry registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_valid_q <= 1'b0;
            head_alu_q   <= '0;
            head_mem_q   <= '0;
            head_instr_q <= '0;
            skid_valid_q <= 1'b0;
            skid_alu_q   <= '0;
            skid_mem_q   <= '0;
            skid_instr_q <= '0;
            occ_q        <= 2'd0;
        end else begin
            head_valid_q <= head_valid_d;
            head_alu_q   <= head_alu_d;
            head_mem_q   <= head_mem_d;
            head_instr_q <= head_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_alu_q   <= skid_alu_d;
            skid_mem_q   <= skid_mem_d;
            skid_instr_q <= skid_instr_d;
            occ_q        <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_reg_mem_wb_elastic.sv
// Randomised bench for the MEM/WB elastic register, checked against a FIFO-of-ops model.
module tb_pipe_reg_mem_wb_elastic;

    typedef struct packed {
        logic [19:0] alu;
        logic [19:0] mem;
        logic [19:0] instr;
    } op_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b1;
    logic        in_ready;
    logic [19:0] alu_result = 20'h0;
    logic [19:0] mem_rdata = 20'h0;
    logic [19:0] instruction = 20'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] alu_out;
    logic [19:0] mem_out;
    logic [19:0] instr_out;
    logic [19:0] wb_data;
    logic [1:0]  occupancy;

    int n_cmp = 0;
    int n_bad = 0;
    op_t mq[$];

    pipe_reg_mem_wb_elastic dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .mem_out(mem_out), .instr_out(instr_out),
        .wb_data(wb_data), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the stage is an in-order queue of at most two ops; it accepts only when fewer than two are held.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else if (in_valid && mq.size() < 2) begin
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            mq.push_back(op_t'{alu_result, mem_rdata, instruction});
        end else if (out_ready && mq.size() > 0) begin
            void'(mq.pop_front());
        end
    end

    // Compare process: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_occupancy", {30'd0, occupancy}, 32'd0);
            check("rst_alu_out", {12'd0, alu_out}, 32'd0);
            check("rst_mem_out", {12'd0, mem_out}, 32'd0);
            check("rst_instr_out", {12'd0, instr_out}, 32'd0);
        end else begin
            check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            check("occupancy", {30'd0, occupancy}, mq.size());
            check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            if (mq.size() > 0) begin
                check("alu_out", {12'd0, alu_out}, {12'd0, mq[0].alu});
                check("mem_out", {12'd0, mem_out}, {12'd0, mq[0].mem});
                check("instr_out", {12'd0, instr_out}, {12'd0, mq[0].instr});
                check("wb_data", {12'd0, wb_data},
                      {12'd0, (mq[0].instr[19:16] == 4'h2) ? mq[0].mem : mq[0].alu});
            end
        end
    end

    // Apply one set of inputs for exactly one rising edge, returning at the following falling edge.
    task automatic drive(input logic iv, input logic [19:0] alu, input logic [19:0] mem,
                         input logic [19:0] ins, input logic ordy, input logic fl);
        in_valid    = iv;
        alu_result  = alu;
        mem_rdata   = mem;
        instruction = ins;
        out_ready   = ordy;
        flush       = fl;
        @(negedge clock);
    endtask

    initial begin
        // Reset held with in_valid high.
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("pin_in_ready_after_release", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0);

        // Streaming with WB always ready.
        drive(1'b1, 20'h00011, 20'h00101, 20'h10001, 1'b1, 1'b0);
        check("pin_stream_head0", {12'd0, alu_out}, 32'h00011);
        drive(1'b1, 20'h00022, 20'h00202, 20'h10002, 1'b1, 1'b0);
        check("pin_stream_head1", {12'd0, alu_out}, 32'h00022);
        drive(1'b1, 20'h00033, 20'h00303, 20'h10003, 1'b1, 1'b0);
        check("pin_stream_head2", {12'd0, alu_out}, 32'h00033);
        check("pin_stream_occ", {30'd0, occupancy}, 32'd1);
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b1, 1'b0);

        // Backpressure: fill both entries, hold C while stalled, then drain.
        drive(1'b1, 20'h0000A, 20'h000A0, 20'h1000A, 1'b0, 1'b0);
        drive(1'b1, 20'h0000B, 20'h000B0, 20'h1000B, 1'b0, 1'b0);
        check("pin_bp_occ", {30'd0, occupancy}, 32'd2);
        check("pin_bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("pin_bp_head", {12'd0, alu_out}, 32'h0000A);
        drive(1'b1, 20'h0000C, 20'h000C0, 20'h1000C, 1'b0, 1'b0);
        drive(1'b1, 20'h0000C, 20'h000C0, 20'h1000C, 1'b1, 1'b0);
        check("pin_bp_pop_b", {12'd0, alu_out}, 32'h0000B);
        drive(1'b1, 20'h0000C, 20'h000C0, 20'h1000C, 1'b1, 1'b0);
        check("pin_bp_pop_c", {12'd0, alu_out}, 32'h0000C);
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b1, 1'b0);
        check("pin_bp_empty", {31'd0, out_valid}, 32'd0);

        // Write-back select: load opcode picks memory data, others the ALU result.
        drive(1'b1, 20'h12345, 20'hABCDE, 20'h2F0F0, 1'b0, 1'b0);
        check("pin_wb_load", {12'd0, wb_data}, 32'hABCDE);
        drive(1'b1, 20'h12345, 20'hABCDE, 20'h1F0F0, 1'b1, 1'b0);
        check("pin_wb_alu", {12'd0, wb_data}, 32'h12345);
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b1, 1'b0);

        // Flush with both entries full and an op offered, then flush discarding a live accept.
        drive(1'b1, 20'h00F01, 20'h00F11, 20'h20F01, 1'b0, 1'b0);
        drive(1'b1, 20'h00F02, 20'h00F12, 20'h20F02, 1'b0, 1'b0);
        drive(1'b1, 20'h00F03, 20'h00F13, 20'h20F03, 1'b0, 1'b1);
        check("pin_flush_valid", {31'd0, out_valid}, 32'd0);
        check("pin_flush_occ", {30'd0, occupancy}, 32'd0);
        check("pin_flush_in_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 20'h00F04, 20'h00F14, 20'h10F04, 1'b1, 1'b1);
        check("pin_flush_accept_dropped", {30'd0, occupancy}, 32'd0);
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle with both entries full.
        drive(1'b1, 20'h00AA1, 20'h00AA2, 20'h10AA1, 1'b0, 1'b0);
        drive(1'b1, 20'h00BB1, 20'h00BB2, 20'h10BB1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("pin_async_valid", {31'd0, out_valid}, 32'd0);
        check("pin_async_occ", {30'd0, occupancy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0);

        // Random traffic with occasional flush; opcode biased toward the load value.
        for (int i = 0; i < 400; i++) begin
            logic [19:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 2) == 0) ins[19:16] = 4'h2;
            drive($urandom_range(0, 3) != 0, 20'($urandom), 20'($urandom), ins,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end

        // Drain.
        repeat (4) drive(1'b0, 20'h0, 20'h0, 20'h0, 1'b1, 1'b0);
        check("pin_final_empty", {30'd0, occupancy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
